// File: rtl/riscv_core_pkg.sv
// Shared types for the RV32 M-extension unit: funct3 op encoding, FSM states
// and the divider counter width helper.
package riscv_core_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  function automatic int unsigned cnt_w(input int unsigned xlen);
    return (xlen > 1) ? $clog2(xlen) : 1;
  endfunction

endpackage

// File: rtl/riscv_core_mdu_if.sv
// Request/response bundle between the execute stage (master) and the MDU (slave).
// Signal names follow the MDU's point of view.
interface riscv_core_mdu_if #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_srcA;
  logic [XLEN-1:0] i_srcB;
  logic [TAGW-1:0] i_tag;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic [TAGW-1:0] o_tag;
  logic            o_busy;

  modport master (
    output i_valid, i_op, i_srcA, i_srcB, i_tag, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_tag, o_busy
  );

  modport slave (
    input  i_valid, i_op, i_srcA, i_srcB, i_tag, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_tag, o_busy
  );
endinterface

// File: rtl/riscv_core_div_iter.sv
// Restoring shift/trial-subtract divider core: one quotient bit per i_step,
// operating on unsigned magnitudes loaded by i_load.
module riscv_core_div_iter
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quo,
  output logic [XLEN-1:0] o_rem
);
  localparam int CW = cnt_w(XLEN);

  logic [XLEN-1:0] r_quo, r_rem, r_div;
  logic [CW-1:0]   r_cnt;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  // The partial remainder needs one extra bit after the shift before the trial compare
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift[XLEN-1:0] - r_div;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_div <= i_divisor;
      r_cnt <= CW'(XLEN - 1);
    end else if (i_step) begin
      r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_ge};
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_done = (r_cnt == '0);
  assign o_quo  = r_quo;
  assign o_rem  = r_rem;
endmodule

// File: rtl/riscv_core_mdu.sv
// RV32 M-extension unit: two-edge multiplier, iterative divider with sign fix-up,
// valid/ready on both sides and a flush that squashes the in-flight operation.
module riscv_core_mdu
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input logic               i_clk,
  input logic               i_rst,
  riscv_core_mdu_if.slave   bus
);
  mdu_state_e      r_state;
  mdu_op_e         r_op;
  logic [XLEN-1:0] r_a, r_b, r_result;
  logic [TAGW-1:0] r_tag;
  logic            r_valid, r_phase, r_neg_q, r_neg_r;

  mdu_op_e           w_op;
  logic              w_signed_div, w_is_rem, w_div_zero, w_ovf, w_load, w_step, w_iter_done;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_quo_fx, w_rem_fx, w_fix_res, w_mul_res;
  logic              w_sa, w_sb;
  logic [2*XLEN-1:0] w_ma, w_mb, w_prod;

  assign w_op         = mdu_op_e'(bus.i_op);
  assign w_signed_div = (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_is_rem     = (w_op == OP_REM) || (w_op == OP_REMU);
  assign w_div_zero   = (bus.i_srcB == '0);
  assign w_ovf        = w_signed_div && (bus.i_srcA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.i_srcB == '1);
  assign w_mag_a      = (w_signed_div && bus.i_srcA[XLEN-1]) ? -bus.i_srcA : bus.i_srcA;
  assign w_mag_b      = (w_signed_div && bus.i_srcB[XLEN-1]) ? -bus.i_srcB : bus.i_srcB;
  assign w_load       = (r_state == ST_IDLE) && bus.i_valid && !bus.i_flush && bus.i_op[2]
                        && !w_div_zero && !w_ovf;
  assign w_step       = (r_state == ST_DIV) && !bus.i_flush;

  riscv_core_div_iter #(.XLEN(XLEN)) u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_done     (w_iter_done),
    .o_quo      (w_quo),
    .o_rem      (w_rem)
  );

  // Sign-extending both operands to 2*XLEN makes one unsigned multiply serve all four variants
  assign w_sa      = (r_op == OP_MULH) || (r_op == OP_MULHSU);
  assign w_sb      = (r_op == OP_MULH);
  assign w_ma      = {{XLEN{w_sa & r_a[XLEN-1]}}, r_a};
  assign w_mb      = {{XLEN{w_sb & r_b[XLEN-1]}}, r_b};
  assign w_prod    = w_ma * w_mb;
  assign w_mul_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  assign w_quo_fx  = r_neg_q ? -w_quo : w_quo;
  assign w_rem_fx  = r_neg_r ? -w_rem : w_rem;
  assign w_fix_res = ((r_op == OP_REM) || (r_op == OP_REMU)) ? w_rem_fx : w_quo_fx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_MUL;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_tag    <= '0;
      r_valid  <= 1'b0;
      r_phase  <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (bus.i_flush) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_phase <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.i_valid) begin
          r_op    <= w_op;
          r_tag   <= bus.i_tag;
          r_a     <= bus.i_srcA;
          r_b     <= bus.i_srcB;
          r_phase <= 1'b0;
          if (!bus.i_op[2]) begin
            r_state <= ST_MUL;
          end else if (w_div_zero) begin
            r_result <= w_is_rem ? bus.i_srcA : '1;
            r_valid  <= 1'b1;
            r_state  <= ST_DONE;
          end else if (w_ovf) begin
            r_result <= w_is_rem ? '0 : bus.i_srcA;
            r_valid  <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_neg_q <= w_signed_div && (bus.i_srcA[XLEN-1] ^ bus.i_srcB[XLEN-1]);
            r_neg_r <= w_signed_div && bus.i_srcA[XLEN-1];
            r_state <= ST_DIV;
          end
        end
        // MUL and FIX both write o_result on their first edge and raise o_valid on the second
        ST_MUL, ST_FIX: begin
          if (!r_phase) begin
            r_result <= (r_state == ST_MUL) ? w_mul_res : w_fix_res;
            r_phase  <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DIV: if (w_iter_done) r_state <= ST_FIX;
        ST_DONE: if (bus.i_ready) begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready  = (r_state == ST_IDLE);
  assign bus.o_busy   = (r_state != ST_IDLE);
  assign bus.o_valid  = r_valid;
  assign bus.o_result = r_result;
  assign bus.o_tag    = r_tag;
endmodule

// File: tb/tb_riscv_core_mdu.sv
// Bench for riscv_core_mdu: directed vector table, randomized ops against an
// arithmetic reference model, and backpressure/flush/reset sequences.
module tb_riscv_core_mdu;
  localparam int XLEN = 32;
  localparam int TAGW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  riscv_core_mdu_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

  riscv_core_mdu #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model computed from the M-extension arithmetic rules
  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin pu = ua * ub; return pu[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        pu = ua / ub; return pu[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        pu = ua % ub; return pu[31:0];
      end
    endcase
  endfunction

  // Edges after the accept edge until o_valid is seen; short-circuit divides are done on the accept edge
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 0;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return XLEN + 2;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    bus.i_op    = op;
    bus.i_srcA  = a;
    bus.i_srcB  = b;
    bus.i_tag   = tag;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (!bus.o_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.o_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: o_valid=0 after %0d edges, required 1", name, lat);
    end
  endtask

  task automatic consume();
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag);
    int lat;
    check({name, "_ready"}, 64'(bus.o_ready), 64'd1);
    issue(op, a, b, tag);
    wait_valid(name, lat);
    check({name, "_result"}, 64'(bus.o_result), 64'(ref_mdu(op, a, b)));
    check({name, "_tag"}, 64'(bus.o_tag), 64'(tag));
    check({name, "_lat"}, 64'(lat), 64'(ref_lat(op, a, b)));
    consume();
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int  lat;
    bit  seen;
    bus.i_valid = 1'b0;
    bus.i_op    = 3'd0;
    bus.i_srcA  = '0;
    bus.i_srcB  = '0;
    bus.i_tag   = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;

    vecs = '{
      '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 2},
      '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 2},
      '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFF, 2},
      '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 2},
      '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 34},
      '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 34},
      '{3'd5, 32'd100,        32'd7,         5'd9,  32'd14,        34},
      '{3'd7, 32'd100,        32'd7,         5'd10, 32'd2,         34},
      '{3'd5, 32'h0000_1234, 32'd0,         5'd11, 32'hFFFF_FFFF, 0},
      '{3'd7, 32'h0000_1234, 32'd0,         5'd12, 32'h0000_1234, 0},
      '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0},
      '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         0},
      '{3'd4, 32'd5,          32'd0,         5'd15, 32'hFFFF_FFFF, 0},
      '{3'd6, 32'd7,          32'hFFFF_FFFE, 5'd31, 32'd1,         34}
    };

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid",  64'(bus.o_valid),  64'd0);
    check("rst_result", 64'(bus.o_result), 64'd0);
    check("rst_tag",    64'(bus.o_tag),    64'd0);
    check("rst_busy",   64'(bus.o_busy),   64'd0);
    check("rst_ready",  64'(bus.o_ready),  64'd1);

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_valid($sformatf("vec%0d", i), lat);
      check($sformatf("vec%0d_result", i), 64'(bus.o_result), 64'(vecs[i].exp));
      check($sformatf("vec%0d_tag", i),    64'(bus.o_tag),    64'(vecs[i].tag));
      check($sformatf("vec%0d_lat", i),    64'(lat),          64'(vecs[i].lat));
      consume();
    end

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run_check($sformatf("rnd%0d_op%0d", i, op), op, a, b, 5'($urandom));
    end

    // Backpressure: result held while i_ready stays low
    issue(3'd5, 32'd100, 32'd7, 5'd9);
    wait_valid("bp", lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_result", i), 64'(bus.o_result), 64'd14);
      check($sformatf("bp%0d_tag", i),    64'(bus.o_tag),    64'd9);
      check($sformatf("bp%0d_ready", i),  64'(bus.o_ready),  64'd0);
      check($sformatf("bp%0d_valid", i),  64'(bus.o_valid),  64'd1);
    end
    consume();
    check("bp_ready_after", 64'(bus.o_ready), 64'd1);
    check("bp_valid_after", 64'(bus.o_valid), 64'd0);
    run_check("bp_next", 3'd0, 32'd6, 32'd7, 5'd1);

    // Flush mid-divide with a competing request
    issue(3'd4, 32'd1000, 32'd3, 5'd4);
    repeat (10) @(posedge clk);
    #1;
    bus.i_flush = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_op    = 3'd3;
    bus.i_srcA  = 32'd9;
    bus.i_srcB  = 32'd9;
    bus.i_tag   = 5'd7;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    check("flush_ready", 64'(bus.o_ready), 64'd1);
    check("flush_busy",  64'(bus.o_busy),  64'd0);
    check("flush_valid", 64'(bus.o_valid), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.o_valid) seen = 1'b1;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    check("flush_idle",     64'(bus.o_ready), 64'd1);
    run_check("flush_next", 3'd0, 32'd12345, 32'd678, 5'd17);

    // Reset during DIV
    issue(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd22);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rdiv_valid",  64'(bus.o_valid),  64'd0);
    check("rdiv_result", 64'(bus.o_result), 64'd0);
    check("rdiv_tag",    64'(bus.o_tag),    64'd0);
    check("rdiv_busy",   64'(bus.o_busy),   64'd0);
    check("rdiv_ready",  64'(bus.o_ready),  64'd1);

    // Reset while a result is waiting in DONE
    issue(3'd0, 32'd3, 32'd5, 5'd21);
    wait_valid("rdone", lat);
    check("rdone_pre", 64'(bus.o_result), 64'd15);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rdone_valid",  64'(bus.o_valid),  64'd0);
    check("rdone_result", 64'(bus.o_result), 64'd0);
    check("rdone_tag",    64'(bus.o_tag),    64'd0);
    check("rdone_busy",   64'(bus.o_busy),   64'd0);
    check("rdone_ready",  64'(bus.o_ready),  64'd1);
    run_check("post_rst_div", 3'd4, 32'hFFFF_FF9C, 32'd7, 5'd22);
    run_check("post_rst_rem", 3'd6, 32'hFFFF_FF9C, 32'd7, 5'd23);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
